// File: rtl/vector_alu_seq.sv
// -----------------------------------------------------------------------------
// vector_alu_seq
//
// Lane-serial vector ALU between the vector register file read ports (RD1/RD2)
// and its write port (WD3/A3/WE3/SFlag). On a start strobe in IDLE it latches
// two LANES x W operand vectors and the control fields. It then computes one
// lane per cycle in EXEC and presents the result for exactly one cycle in WB.
// Scalar mode computes lane 0 only, against one selected lane of b.
//
// Optional feature macro: VALU_SATURATE_EN
//   defined   : ADD clamps at all-ones, SUB clamps at zero (unsigned)
//   undefined : ADD and SUB wrap modulo 2**W
//
// Ports
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-high reset
//   start    in   launch; sampled only in IDLE
//   op       in   3-bit opcode (ADD SUB AND OR XOR SHL SHR MOV)
//   sflag_i  in   1 = scalar operation
//   b_idx    in   scalar operand lane select into b (6/7 -> operand 0)
//   dst      in   destination register index
//   a, b     in   LANES*W operand vectors
//   busy     out  high while not IDLE
//   we       out  one-cycle write enable
//   wd       out  write data (held until next WB)
//   wa       out  write index (held)
//   sflag_o  out  scalar write flag (held)
//   zero     out  all written lanes zero (held)
//
// state | meaning
// IDLE  | waiting for start, outputs hold last write-back values
// EXEC  | one lane per cycle (vector) or lane 0 only (scalar)
// WB    | we high for this one cycle, then back to IDLE
// -----------------------------------------------------------------------------
module vector_alu_seq #(
    parameter int LANES = 6,
    parameter int W     = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [2:0]         op,
    input  logic               sflag_i,
    input  logic [2:0]         b_idx,
    input  logic [3:0]         dst,
    input  logic [LANES*W-1:0] a,
    input  logic [LANES*W-1:0] b,
    output logic               busy,
    output logic               we,
    output logic [LANES*W-1:0] wd,
    output logic [3:0]         wa,
    output logic               sflag_o,
    output logic               zero
);

    localparam int CW = $clog2(LANES);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MOV = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t               state;
    logic [2:0]           op_r;
    logic                 sflag_r;
    logic [2:0]           bidx_r;
    logic [3:0]           dst_r;
    logic [LANES*W-1:0]   a_r;
    logic [LANES*W-1:0]   b_r;
    logic [LANES*W-1:0]   res_r;
    logic [CW-1:0]        cnt;

    logic [W-1:0]         lane_a;
    logic [W-1:0]         lane_b;
    logic [W-1:0]         lane_res;
    logic [LANES*W-1:0]   res_next;
    logic                 last_lane;

    function automatic logic [W-1:0] lane_op(
        input logic [2:0]   o,
        input logic [W-1:0] x,
        input logic [W-1:0] y
    );
        logic [W:0]   s;
        logic [W-1:0] r;
        s = '0;
        r = '0;
        case (o)
            OP_ADD: begin
                s = {1'b0, x} + {1'b0, y};
`ifdef VALU_SATURATE_EN
                r = s[W] ? '1 : s[W-1:0];
`else
                r = s[W-1:0];
`endif
            end
            OP_SUB: begin
                // s[W] is the borrow out of the unsigned subtraction
                s = {1'b0, x} - {1'b0, y};
`ifdef VALU_SATURATE_EN
                r = s[W] ? '0 : s[W-1:0];
`else
                r = s[W-1:0];
`endif
            end
            OP_AND:  r = x & y;
            OP_OR:   r = x | y;
            OP_XOR:  r = x ^ y;
            OP_SHL:  r = x << y[2:0];
            OP_SHR:  r = x >> y[2:0];
            OP_MOV:  r = y;
            default: r = '0;
        endcase
        return r;
    endfunction

    // Operand lane select. In scalar mode cnt stays 0, so lane_a is a[0];
    // lane_b comes from b_idx, and indices past the last lane read as zero.
    always_comb begin
        lane_a = '0;
        lane_b = '0;
        for (int i = 0; i < LANES; i++) begin
            if (cnt == CW'(i)) begin
                lane_a = a_r[i*W +: W];
                if (!sflag_r) begin
                    lane_b = b_r[i*W +: W];
                end
            end
            if (sflag_r && (bidx_r == 3'(i))) begin
                lane_b = b_r[i*W +: W];
            end
        end
    end

    always_comb begin
        lane_res = lane_op(op_r, lane_a, lane_b);
        res_next = res_r;
        for (int i = 0; i < LANES; i++) begin
            if (cnt == CW'(i)) begin
                res_next[i*W +: W] = lane_res;
            end
        end
        last_lane = sflag_r || (cnt == CW'(LANES - 1));
    end

    // The write-back outputs are loaded on the final EXEC edge, so they are
    // already valid for the whole WB cycle while staying fully registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            op_r    <= '0;
            sflag_r <= 1'b0;
            bidx_r  <= '0;
            dst_r   <= '0;
            a_r     <= '0;
            b_r     <= '0;
            res_r   <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
            we      <= 1'b0;
            wd      <= '0;
            wa      <= '0;
            sflag_o <= 1'b0;
            zero    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    we <= 1'b0;
                    if (start) begin
                        op_r    <= op;
                        sflag_r <= sflag_i;
                        bidx_r  <= b_idx;
                        dst_r   <= dst;
                        a_r     <= a;
                        b_r     <= b;
                        res_r   <= '0;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    res_r <= res_next;
                    cnt   <= cnt + 1'b1;
                    if (last_lane) begin
                        we      <= 1'b1;
                        wd      <= res_next;
                        wa      <= dst_r;
                        sflag_o <= sflag_r;
                        zero    <= (res_next == '0);
                        state   <= WB;
                    end
                end
                WB: begin
                    we    <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    we    <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vector_alu_seq.sv
module tb_vector_alu_seq;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MOV = 3'b111;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic        sflag_i;
    logic [2:0]  b_idx;
    logic [3:0]  dst;
    logic [47:0] a;
    logic [47:0] b;
    logic        busy;
    logic        we;
    logic [47:0] wd;
    logic [3:0]  wa;
    logic        sflag_o;
    logic        zero;

    vector_alu_seq #(.LANES(6), .W(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .sflag_i (sflag_i),
        .b_idx   (b_idx),
        .dst     (dst),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .we      (we),
        .wd      (wd),
        .wa      (wa),
        .sflag_o (sflag_o),
        .zero    (zero)
    );

    always #5 clk = ~clk;

    int ec = 0;
    always @(posedge clk) ec <= ec + 1;

    typedef struct {
        logic [47:0] wd;
        logic [3:0]  wa;
        logic        sf;
        logic        z;
        int          ec;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every write-back pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        if (!rst && we) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_we: got we=1 at edge %0d expected no write", ec);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("wd", 64'(wd), 64'(e.wd));
                chk("wa", 64'(wa), 64'(e.wa));
                chk("sflag_o", 64'(sflag_o), 64'(e.sf));
                chk("zero", 64'(zero), 64'(e.z));
                chk("we_edge", 64'(ec), 64'(e.ec));
                chk("busy_in_wb", 64'(busy), 64'd1);
            end
        end
    end

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 30 && !done; i++) begin
            @(negedge clk);
            if (!busy) done = 1'b1;
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL busy_timeout: busy still 1 after 30 cycles, expected 0");
        end
    endtask

    task automatic drive(input logic [2:0] o, input logic sf, input logic [2:0] bi,
                         input logic [3:0] d, input logic [47:0] av, input logic [47:0] bv);
        op = o; sflag_i = sf; b_idx = bi; dst = d; a = av; b = bv;
    endtask

    task automatic issue(input logic [2:0] o, input logic sf, input logic [2:0] bi,
                         input logic [3:0] d, input logic [47:0] av, input logic [47:0] bv,
                         input logic [47:0] ew, input logic ez);
        int s;
        drive(o, sf, bi, d, av, bv);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        s = ec;
        q.push_back('{ew, d, sf, ez, s + (sf ? 1 : 6)});
        chk("busy_rise", 64'(busy), 64'd1);
        chk("we_low_after_start", 64'(we), 64'd0);
        wait_idle();
    endtask

    initial begin
        int s;
        rst = 1'b1;
        start = 1'b0;
        drive(OP_ADD, 1'b0, 3'd0, 4'd0, 48'h0, 48'h0);
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_we", 64'(we), 64'd0);
        chk("rst_wd", 64'(wd), 64'd0);
        chk("rst_wa", 64'(wa), 64'd0);
        chk("rst_sflag_o", 64'(sflag_o), 64'd0);
        chk("rst_zero", 64'(zero), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // vector ADD
        issue(OP_ADD, 1'b0, 3'd0, 4'd8, 48'h060504030201, 48'h010101010101,
              48'h070605040302, 1'b0);
        // SUB underflow in lane 0
`ifdef VALU_SATURATE_EN
        issue(OP_SUB, 1'b0, 3'd0, 4'd1, 48'h050505050500, 48'h050505050501,
              48'h000000000000, 1'b1);
`else
        issue(OP_SUB, 1'b0, 3'd0, 4'd1, 48'h050505050500, 48'h050505050501,
              48'h0000000000FF, 1'b0);
`endif
        // scalar XOR: 10 ^ b[2]=DD -> CD, other a lanes must not leak
        issue(OP_XOR, 1'b1, 3'd2, 4'd3, 48'h112233445510, 48'hFF00FFDD00FF,
              48'h0000000000CD, 1'b0);
        // shifts, amount from bits [2:0] only
        issue(OP_SHL, 1'b0, 3'd0, 4'd4, 48'h3C3C3C8101FF, 48'h02020200_0F09,
              48'hF0F0F08180FE, 1'b0);
        issue(OP_SHR, 1'b0, 3'd0, 4'd4, 48'hAAAAAAF080FF, 48'hF9F9F9040709,
              48'h5555550F017F, 1'b0);
        // AND, and XOR of equal vectors gives zero=1
        issue(OP_AND, 1'b0, 3'd0, 4'd10, 48'hF0F0F0F0F0F0, 48'h0FF0FF003C3C,
              48'h00F0F0003030, 1'b0);
        issue(OP_XOR, 1'b0, 3'd0, 4'd11, 48'h123456789ABC, 48'h123456789ABC,
              48'h000000000000, 1'b1);
        // scalar MOV with out-of-range index selects 0
        issue(OP_MOV, 1'b1, 3'd7, 4'd15, 48'hFFFFFFFFFFFF, 48'hFFFFFFFFFFFF,
              48'h000000000000, 1'b1);
        // scalar ADD from the top lane: F0 + 20
`ifdef VALU_SATURATE_EN
        issue(OP_ADD, 1'b1, 3'd5, 4'd12, 48'h0000000000F0, 48'h200000000000,
              48'h0000000000FF, 1'b0);
`else
        issue(OP_ADD, 1'b1, 3'd5, 4'd12, 48'h0000000000F0, 48'h200000000000,
              48'h000000000010, 1'b0);
`endif

        // start held while busy with other operands: first result unchanged,
        // second op launches from those operands once IDLE is reached
        drive(OP_OR, 1'b0, 3'd0, 4'd5, 48'h010203040506, 48'h101010101010);
        start = 1'b1;
        @(posedge clk);
        #1;
        s = ec;
        q.push_back('{48'h111213141516, 4'd5, 1'b0, 1'b0, s + 6});
        drive(OP_MOV, 1'b0, 3'd0, 4'd6, 48'hFFFFFFFFFFFF, 48'hA5A5A5A5A5A5);
        q.push_back('{48'hA5A5A5A5A5A5, 4'd6, 1'b0, 1'b0, s + 14});
        repeat (8) @(posedge clk);
        #1;
        start = 1'b0;
        chk("relaunch_busy", 64'(busy), 64'd1);
        wait_idle();

        // reset mid-EXEC: aborted op never writes
        drive(OP_ADD, 1'b0, 3'd0, 4'd7, 48'h010101010101, 48'h010101010101);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_we", 64'(we), 64'd0);
        chk("abort_wd", 64'(wd), 64'd0);
        chk("abort_wa", 64'(wa), 64'd0);
        chk("abort_sflag_o", 64'(sflag_o), 64'd0);
        chk("abort_zero", 64'(zero), 64'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        issue(OP_ADD, 1'b0, 3'd0, 4'd9, 48'h060504030201, 48'h010101010101,
              48'h070605040302, 1'b0);

        repeat (4) @(negedge clk);
        chk("queue_drained", 64'(q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running, expected finish");
        $fatal(1);
    end

endmodule
